// File: rtl/shifter_defs_pkg.sv
// -----------------------------------------------------------------------------
// shifter_defs: shared constants for the serial and combinational shift units.
//   state_e     : serial shifter FSM encoding (ST_IDLE, ST_SHIFT, ST_DONE)
//   DIR_*       : shift direction encoding of the LR control bit
//   MODE_*      : fill mode encoding of the AL control bit
// -----------------------------------------------------------------------------
package shifter_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic DIR_RIGHT  = 1'b0;
  localparam logic DIR_LEFT   = 1'b1;

  localparam logic MODE_LOGIC = 1'b0;
  localparam logic MODE_ARITH = 1'b1;

endpackage : shifter_defs

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step: combinational shift of a word by exactly one bit position.
//   dir  in  1       DIR_LEFT or DIR_RIGHT
//   fill in  1       bit entering the MSB on a right shift (ignored on left)
//   d    in  DWIDTH  operand
//   q    out DWIDTH  shifted operand; left shifts always bring in a zero
// -----------------------------------------------------------------------------
module shift_step
  import shifter_defs::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              dir,
  input  logic              fill,
  input  logic [DWIDTH-1:0] d,
  output logic [DWIDTH-1:0] q
);

  assign q = (dir == DIR_LEFT) ? {d[DWIDTH-2:0], 1'b0}
                               : {fill, d[DWIDTH-1:1]};

endmodule : shift_step

// File: rtl/serial_shifter.sv
// -----------------------------------------------------------------------------
// serial_shifter: low-area shifter that moves the operand one bit per clock.
// Bit-identical to the combinational barrel shifter for the same AL/LR/shamt/din.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake; in_ready is high only in IDLE
//   AL, LR, shamt, din    request fields, sampled only at the accept edge
//   out_valid / out_ready result handshake; result held while out_ready is low
//   dout                  result, driven straight from the data register
//   busy                  high whenever the FSM is not IDLE
// Latency: out_valid rises shamt+1 cycles after the accept edge.
// -----------------------------------------------------------------------------
module serial_shifter
  import shifter_defs::*;
#(
  parameter  int DWIDTH = 8,
  localparam int SDEPTH = $clog2(DWIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              AL,
  input  logic              LR,
  input  logic [SDEPTH-1:0] shamt,
  input  logic [DWIDTH-1:0] din,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] dout,
  output logic              busy
);

  state_e            state_q;
  logic [DWIDTH-1:0] data_q;
  logic [DWIDTH-1:0] data_d;
  logic [SDEPTH-1:0] cnt_q;
  logic              dir_q;
  logic              fill_q;
  logic              out_valid_q;

  // One-position shift on the data_q next-state path.
  shift_step #(
    .DWIDTH (DWIDTH)
  ) u_step (
    .dir  (dir_q),
    .fill (fill_q),
    .d    (data_q),
    .q    (data_d)
  );

  // NOTE: state is written with non-blocking assignments only, so every
  // register in this block samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      cnt_q       <= '0;
      dir_q       <= DIR_RIGHT;
      fill_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            data_q  <= din;
            cnt_q   <= shamt;
            dir_q   <= LR;
            // Sign fill is captured once; a left shift never uses it.
            fill_q  <= (AL == MODE_ARITH) & din[DWIDTH-1];
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt_q == '0) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end else begin
            data_q <= data_d;
            cnt_q  <= cnt_q - SDEPTH'(1);
          end
        end
        ST_DONE: begin
          // Returning to IDLE first means no same-cycle re-accept.
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign dout      = data_q;

endmodule : serial_shifter

// File: tb/tb_serial_shifter.sv
// -----------------------------------------------------------------------------
// tb_serial_shifter: self-checking bench for serial_shifter (DWIDTH=8).
// Table-driven directed vectors, a few random ops against a reference shift
// expression, and hand-written backpressure, in-flight change and reset cases.
// Expected results go into a queue at the accept edge and are compared when
// out_valid appears.
// -----------------------------------------------------------------------------
module tb_serial_shifter;

  localparam int DWIDTH = 8;
  localparam int SDEPTH = 3;
  localparam int TMO    = 40;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              AL;
  logic              LR;
  logic [SDEPTH-1:0] shamt;
  logic [DWIDTH-1:0] din;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] dout;
  logic              busy;

  serial_shifter #(.DWIDTH(DWIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .AL        (AL),
    .LR        (LR),
    .shamt     (shamt),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       lr;
    logic       al;
    logic [2:0] sh;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] exp_q [$];
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic lr,
                                           input logic al, input logic [2:0] sh);
    logic [7:0] r;
    if (lr)      r = d << sh;
    else if (al) r = $signed(d) >>> sh;
    else         r = d >> sh;
    return r;
  endfunction

  // Called at posedge+1. Waits for out_valid, checks latency, busy and value.
  task automatic wait_result(input string name, input int exp_lat);
    int   cyc     = 0;
    logic busy_ok = busy;
    while (!out_valid && cyc < TMO) begin
      @(posedge clk); #1;
      cyc++;
      if (!out_valid) busy_ok &= busy;
    end
    check({name, "_latency"}, cyc, exp_lat);
    check({name, "_busy"}, {31'd0, busy_ok & busy}, 32'd1);
    if (exp_q.size() == 0) begin
      check({name, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      check({name, "_dout"}, {24'd0, dout}, {24'd0, exp_q.pop_front()});
    end
  endtask

  // Called at posedge+1 while DONE. Completes the handshake, checks return to IDLE.
  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_idle"}, {29'd0, out_valid, busy, in_ready}, 32'b001);
  endtask

  // Called at posedge+1 in IDLE. Runs one op; fields are scrambled after accept.
  task automatic run_op(input string name, input logic [7:0] d, input logic lr,
                        input logic al, input logic [2:0] sh, input logic [7:0] exp,
                        input logic rdy_early);
    int w = 0;
    while (!in_ready && w < TMO) begin @(posedge clk); #1; w++; end
    check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; din = d; LR = lr; AL = al; shamt = sh;
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
    in_valid = 1'b0; din = ~d; LR = ~lr; AL = ~al; shamt = ~sh;
    out_ready = rdy_early;
    wait_result(name, int'(sh) + 1);
    handshake(name);
  endtask

  initial begin
    vecs[0] = '{d: 8'h96, lr: 1'b1, al: 1'b0, sh: 3'd3, exp: 8'hB0};
    vecs[1] = '{d: 8'h96, lr: 1'b0, al: 1'b1, sh: 3'd2, exp: 8'hE5};
    vecs[2] = '{d: 8'h96, lr: 1'b0, al: 1'b0, sh: 3'd2, exp: 8'h25};
    vecs[3] = '{d: 8'h80, lr: 1'b0, al: 1'b1, sh: 3'd7, exp: 8'hFF};
    vecs[4] = '{d: 8'h5A, lr: 1'b1, al: 1'b0, sh: 3'd0, exp: 8'h5A};
    vecs[5] = '{d: 8'h5A, lr: 1'b0, al: 1'b1, sh: 3'd0, exp: 8'h5A};
    vecs[6] = '{d: 8'h01, lr: 1'b1, al: 1'b1, sh: 3'd7, exp: 8'h80};
    vecs[7] = '{d: 8'h0F, lr: 1'b1, al: 1'b0, sh: 3'd4, exp: 8'hF0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    AL = 1'b0; LR = 1'b0; shamt = '0; din = '0;
    #12;
    check("reset_outputs", {20'd0, dout, out_valid, busy, in_ready}, {20'd0, 8'h00, 3'b001});
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_outputs", {20'd0, dout, out_valid, busy, in_ready}, {20'd0, 8'h00, 3'b001});

    // Directed table
    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].lr, vecs[i].al,
             vecs[i].sh, vecs[i].exp, 1'b0);

    // Random ops; out_ready raised early to show it is ignored outside DONE
    for (int i = 0; i < 6; i++) begin
      logic [7:0] d  = 8'($urandom);
      logic       lr = 1'($urandom);
      logic       al = 1'($urandom);
      logic [2:0] sh = 3'($urandom_range(7, 0));
      run_op($sformatf("rand%0d", i), d, lr, al, sh, ref_shift(d, lr, al, sh), 1'b1);
    end

    // Fields changed while SHIFT is in progress
    in_valid = 1'b1; din = 8'h96; LR = 1'b1; AL = 1'b0; shamt = 3'd3;
    @(posedge clk);
    exp_q.push_back(8'hB0);
    #1;
    in_valid = 1'b1; din = 8'hFF; LR = 1'b0; shamt = 3'd1;
    @(posedge clk); #1;
    check("inflight_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    wait_result("inflight", 3);

    // Backpressure: new request pending while the result is held
    in_valid = 1'b1; din = 8'h0F; LR = 1'b1; AL = 1'b0; shamt = 3'd4;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d", i), {20'd0, dout, out_valid, busy, in_ready},
            {20'd0, 8'hB0, 3'b110});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_idle", {29'd0, out_valid, busy, in_ready}, 32'b001);
    @(posedge clk);
    exp_q.push_back(8'hF0);
    #1;
    in_valid = 1'b0;
    check("bp_accepted", {31'd0, busy}, 32'd1);
    wait_result("bp_pending", 5);
    handshake("bp_pending");

    // Reset during SHIFT
    in_valid = 1'b1; din = 8'hC3; LR = 1'b1; AL = 1'b0; shamt = 3'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {20'd0, dout, out_valid, busy, in_ready}, {20'd0, 8'h00, 3'b001});
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        seen |= out_valid | busy;
      end
      check("rst_no_stale_valid", {31'd0, seen}, 32'd0);
    end
    run_op("after_rst", 8'h0F, 1'b1, 1'b0, 3'd4, 8'hF0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_serial_shifter
